// File: rtl/snowbro2_eeprom_93c46.sv
// 93C46 (64x16) serial EEPROM responder for snowbro2, oversampling SCS/SCLK/SDI on the CPU clock.
// Latency: SDO updates 3 CLK after a raw SCLK rise; NV_DOUT is registered with 1-CLK latency.
// Backpressure: none; SDO low reports busy while SCS is high and a program cycle is pending.
module snowbro2_eeprom_93c46 #(
    parameter int ADDR_W      = 6,
    parameter int DATA_W      = 16,
    parameter int BUSY_CYCLES = 48000
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              SCS,
    input  logic              SCLK,
    input  logic              SDI,
    output logic              SDO,
    input  logic [ADDR_W-1:0] NV_ADDR,
    input  logic [DATA_W-1:0] NV_DIN,
    input  logic              NV_WE,
    output logic [DATA_W-1:0] NV_DOUT
);
    localparam int CW    = $clog2(((DATA_W > ADDR_W) ? DATA_W : ADDR_W) + 1);
    localparam int BW    = $clog2(DATA_W);
    localparam int BCW   = $clog2(BUSY_CYCLES + 1);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [3:0] {
        S_IDLE, S_OPCODE, S_ADDR, S_READ_OUT, S_WRITE_IN,
        S_WRITE_ARM, S_BUSY, S_COMMIT, S_WAIT_CS
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [1:0]        scs_sync, sclk_sync, sdi_sync;
    logic              sclk_prev;
    logic              scs_s, sdi_s, sclk_rise;
    logic [1:0]        op;
    logic [ADDR_W-1:0] addr, addr_next;
    logic [DATA_W-1:0] data_sr;
    logic [CW-1:0]     cnt;
    logic [BCW-1:0]    busy_cnt;
    logic              ewen, op_full, mem_we;

    assign scs_s     = scs_sync[1];
    assign sdi_s     = sdi_sync[1];
    assign sclk_rise = sclk_sync[1] & ~sclk_prev;
    assign addr_next = {addr[ADDR_W-2:0], sdi_s};

    // Single-word ops commit on the last busy cycle; full-array ops sweep addr through S_COMMIT.
    assign mem_we = (state == S_BUSY && busy_cnt == '0 && !op_full) || (state == S_COMMIT);

    // Array has no reset so contents survive RESET_N; commits take priority over the host port.
    always_ff @(posedge CLK) begin
        if (mem_we)
            mem[addr] <= data_sr;
        else if (NV_WE)
            mem[NV_ADDR] <= NV_DIN;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            scs_sync  <= '0;
            sclk_sync <= '0;
            sdi_sync  <= '0;
            sclk_prev <= 1'b0;
            state     <= S_IDLE;
            SDO       <= 1'b1;
            NV_DOUT   <= '0;
            op        <= '0;
            addr      <= '0;
            data_sr   <= '0;
            cnt       <= '0;
            busy_cnt  <= '0;
            ewen      <= 1'b0;
            op_full   <= 1'b0;
        end else begin
            scs_sync  <= {scs_sync[0], SCS};
            sclk_sync <= {sclk_sync[0], SCLK};
            sdi_sync  <= {sdi_sync[0], SDI};
            sclk_prev <= sclk_sync[1];
            NV_DOUT   <= mem[NV_ADDR];

            if (!scs_s && state != S_WRITE_ARM && state != S_BUSY && state != S_COMMIT) begin
                state <= S_IDLE;
                cnt   <= '0;
                SDO   <= 1'b1;
            end else begin
                case (state)
                    S_IDLE: begin
                        SDO <= 1'b1;
                        if (sclk_rise && sdi_s) begin
                            state <= S_OPCODE;
                            cnt   <= '0;
                        end
                    end
                    S_OPCODE: if (sclk_rise) begin
                        op <= {op[0], sdi_s};
                        if (cnt == CW'(1)) begin
                            state <= S_ADDR;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    S_ADDR: if (sclk_rise) begin
                        addr <= addr_next;
                        if (cnt == CW'(ADDR_W - 1)) begin
                            cnt <= '0;
                            case (op)
                                2'b10: begin
                                    state <= S_READ_OUT;
                                    SDO   <= 1'b0;
                                    cnt   <= CW'(DATA_W - 1);
                                end
                                2'b01: begin
                                    state   <= S_WRITE_IN;
                                    op_full <= 1'b0;
                                end
                                2'b11: begin
                                    state   <= S_WRITE_ARM;
                                    op_full <= 1'b0;
                                    data_sr <= '1;
                                end
                                default: begin
                                    // Opcode 00 extends into the top two address bits.
                                    case (addr_next[ADDR_W-1 -: 2])
                                        2'b11: begin ewen <= 1'b1; state <= S_WAIT_CS; end
                                        2'b00: begin ewen <= 1'b0; state <= S_WAIT_CS; end
                                        2'b10: begin
                                            state   <= S_WRITE_ARM;
                                            op_full <= 1'b1;
                                            data_sr <= '1;
                                        end
                                        default: begin
                                            state   <= S_WRITE_IN;
                                            op_full <= 1'b1;
                                        end
                                    endcase
                                end
                            endcase
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    S_READ_OUT: if (sclk_rise) begin
                        SDO <= mem[addr][cnt[BW-1:0]];
                        if (cnt == '0) begin
                            addr <= addr + ADDR_W'(1);
                            cnt  <= CW'(DATA_W - 1);
                        end else begin
                            cnt <= cnt - CW'(1);
                        end
                    end
                    S_WRITE_IN: if (sclk_rise) begin
                        data_sr <= {data_sr[DATA_W-2:0], sdi_s};
                        if (cnt == CW'(DATA_W - 1))
                            state <= S_WRITE_ARM;
                        else
                            cnt <= cnt + CW'(1);
                    end
                    S_WRITE_ARM: if (!scs_s) begin
                        cnt <= '0;
                        if (ewen) begin
                            state    <= S_BUSY;
                            busy_cnt <= BCW'(BUSY_CYCLES - 1);
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                    S_BUSY: begin
                        SDO <= ~scs_s;
                        if (busy_cnt == '0) begin
                            if (op_full) begin
                                state <= S_COMMIT;
                                addr  <= '0;
                            end else begin
                                state <= S_IDLE;
                                SDO   <= 1'b1;
                            end
                        end else begin
                            busy_cnt <= busy_cnt - BCW'(1);
                        end
                    end
                    S_COMMIT: begin
                        SDO  <= ~scs_s;
                        addr <= addr + ADDR_W'(1);
                        if (addr == '1) begin
                            state <= S_IDLE;
                            SDO   <= 1'b1;
                        end
                    end
                    S_WAIT_CS: SDO <= 1'b1;
                    default:   state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_snowbro2_eeprom_93c46.sv
// Bench for snowbro2_eeprom_93c46: NV port vector table plus serial command sequences
// with an SDO scoreboard; busy time shortened so every program cycle fits the run.
module tb_snowbro2_eeprom_93c46;
    localparam int BUSY = 200;

    logic        CLK = 1'b0, RESET_N = 1'b0, SCS = 1'b0, SCLK = 1'b0, SDI = 1'b0, NV_WE = 1'b0;
    logic [5:0]  NV_ADDR = '0;
    logic [15:0] NV_DIN = '0;
    logic        SDO;
    logic [15:0] NV_DOUT;

    int          tests = 0, fails = 0;
    logic [15:0] model [64];
    logic        exp_q [$];
    logic        last_sdo;

    typedef struct {
        logic        we;
        logic [5:0]  addr;
        logic [15:0] din;
        logic [15:0] exp;
    } nv_vec_t;
    nv_vec_t vecs [11];

    always #5 CLK = ~CLK;

    snowbro2_eeprom_93c46 #(.ADDR_W(6), .DATA_W(16), .BUSY_CYCLES(BUSY)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .SCS(SCS), .SCLK(SCLK), .SDI(SDI), .SDO(SDO),
        .NV_ADDR(NV_ADDR), .NV_DIN(NV_DIN), .NV_WE(NV_WE), .NV_DOUT(NV_DOUT)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic xfer(input logic b);
        @(negedge CLK) SDI = b;
        repeat (3) @(negedge CLK);
        SCLK = 1'b1;
        repeat (8) @(negedge CLK);
        last_sdo = SDO;
        SCLK = 1'b0;
        repeat (4) @(negedge CLK);
    endtask

    task automatic sb_check(input string name);
        logic e;
        if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL %s: scoreboard empty, got %b", name, last_sdo);
        end else begin
            e = exp_q.pop_front();
            check(name, {15'd0, last_sdo}, {15'd0, e});
        end
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [5:0] a);
        @(negedge CLK) SCS = 1'b1;
        repeat (4) @(negedge CLK);
        xfer(1'b1);
        for (int i = 1; i >= 0; i--) xfer(op[i]);
        for (int i = 5; i >= 0; i--) xfer(a[i]);
    endtask

    task automatic send_data(input logic [15:0] d, input int nbits);
        for (int i = 15; i > 15 - nbits; i--) xfer(d[i]);
    endtask

    task automatic cs_low();
        @(negedge CLK) SCS = 1'b0;
        repeat (6) @(negedge CLK);
    endtask

    task automatic nv_read(input string name, input logic [5:0] a);
        @(negedge CLK);
        NV_ADDR = a;
        NV_WE   = 1'b0;
        @(negedge CLK);
        check(name, NV_DOUT, model[a]);
    endtask

    task automatic serial_read(input logic [5:0] a, input int nwords);
        logic [5:0] wa;
        send_cmd(2'b10, a);
        exp_q.push_back(1'b0);
        sb_check("read_dummy");
        for (int w = 0; w < nwords; w++) begin
            wa = a + 6'(w);
            for (int i = 15; i >= 0; i--) begin
                exp_q.push_back(model[wa][i]);
                xfer(1'b0);
                sb_check("read_bit");
            end
        end
        cs_low();
    endtask

    // Raise SCS after a program cycle starts, expect SDO low, then measure how long it stays low.
    task automatic busy_phase(input string name, input int min_c, input int max_c);
        int n;
        @(negedge CLK) SCS = 1'b1;
        repeat (5) @(negedge CLK);
        check({name, "_busy"}, {15'd0, SDO}, 16'd0);
        n = 0;
        while (SDO !== 1'b1 && n < 5000) begin
            @(negedge CLK);
            n++;
        end
        tests++;
        if (n < min_c || n > max_c) begin
            fails++;
            $display("FAIL %s_len: busy lasted %0d cycles, expected %0d..%0d", name, n, min_c, max_c);
        end
        @(negedge CLK) SCS = 1'b0;
        repeat (4) @(negedge CLK);
    endtask

    task automatic no_busy(input string name);
        @(negedge CLK) SCS = 1'b1;
        repeat (8) @(negedge CLK);
        check(name, {15'd0, SDO}, 16'd1);
        @(negedge CLK) SCS = 1'b0;
        repeat (4) @(negedge CLK);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = '{1'b1, 6'd5,  16'h1234, 16'h0000};
        vecs[1]  = '{1'b1, 6'd3,  16'h7777, 16'h0000};
        vecs[2]  = '{1'b1, 6'd10, 16'hBEEF, 16'h0000};
        vecs[3]  = '{1'b1, 6'd63, 16'hC3A5, 16'h0000};
        vecs[4]  = '{1'b1, 6'd0,  16'h8001, 16'h0000};
        vecs[5]  = '{1'b1, 6'd20, 16'h5A5A, 16'h0000};
        vecs[6]  = '{1'b0, 6'd5,  16'h0000, 16'h1234};
        vecs[7]  = '{1'b0, 6'd3,  16'h0000, 16'h7777};
        vecs[8]  = '{1'b0, 6'd10, 16'h0000, 16'hBEEF};
        vecs[9]  = '{1'b0, 6'd63, 16'h0000, 16'hC3A5};
        vecs[10] = '{1'b0, 6'd0,  16'h0000, 16'h8001};

        repeat (3) @(negedge CLK);
        check("reset_sdo", {15'd0, SDO}, 16'd1);
        check("reset_nv_dout", NV_DOUT, 16'h0000);
        RESET_N = 1'b1;
        repeat (3) @(negedge CLK);

        foreach (vecs[k]) begin
            @(negedge CLK);
            NV_ADDR = vecs[k].addr;
            NV_DIN  = vecs[k].din;
            NV_WE   = vecs[k].we;
            @(negedge CLK);
            NV_WE = 1'b0;
            if (vecs[k].we) model[vecs[k].addr] = vecs[k].din;
            else            check("nv_vec", NV_DOUT, vecs[k].exp);
        end

        // Plain read of a host-loaded word.
        serial_read(6'd5, 1);

        // Write without EWEN: no busy phase, word unchanged.
        send_cmd(2'b01, 6'd3);
        send_data(16'h0000, 16);
        cs_low();
        no_busy("nowrite_no_busy");
        nv_read("nowrite_nv3", 6'd3);

        // EWEN then WRITE 3 = A55A.
        send_cmd(2'b00, 6'b110000);
        cs_low();
        send_cmd(2'b01, 6'd3);
        send_data(16'hA55A, 16);
        cs_low();
        busy_phase("write3", BUSY - 20, BUSY);
        model[3] = 16'hA55A;
        nv_read("write3_nv", 6'd3);
        serial_read(6'd3, 1);

        // Sequential read wraps from 63 to 0.
        serial_read(6'd63, 2);

        // Aborted write after 8 data bits.
        send_cmd(2'b01, 6'd10);
        send_data(16'hFFFF, 8);
        cs_low();
        no_busy("abort_no_busy");
        nv_read("abort_nv10", 6'd10);

        // ERASE of a single word.
        send_cmd(2'b11, 6'd5);
        cs_low();
        busy_phase("erase5", BUSY - 20, BUSY);
        model[5] = 16'hFFFF;
        nv_read("erase5_nv", 6'd5);

        // ERAL then WRAL 0F0F.
        send_cmd(2'b00, 6'b110000);
        cs_low();
        send_cmd(2'b00, 6'b100000);
        cs_low();
        busy_phase("eral", BUSY - 20, BUSY + 70);
        for (int i = 0; i < 64; i++) model[i] = 16'hFFFF;
        nv_read("eral_nv0", 6'd0);
        nv_read("eral_nv33", 6'd33);
        nv_read("eral_nv63", 6'd63);
        send_cmd(2'b00, 6'b110000);
        cs_low();
        send_cmd(2'b00, 6'b010000);
        send_data(16'h0F0F, 16);
        cs_low();
        busy_phase("wral", BUSY - 20, BUSY + 70);
        for (int i = 0; i < 64; i++) model[i] = 16'h0F0F;
        nv_read("wral_nv0", 6'd0);
        nv_read("wral_nv63", 6'd63);

        // Reset during BUSY drops the commit and clears EWEN.
        send_cmd(2'b01, 6'd20);
        send_data(16'h1111, 16);
        cs_low();
        @(negedge CLK) SCS = 1'b1;
        repeat (50) @(negedge CLK);
        check("midbusy_sdo", {15'd0, SDO}, 16'd0);
        RESET_N = 1'b0;
        repeat (2) @(negedge CLK);
        check("midbusy_reset_sdo", {15'd0, SDO}, 16'd1);
        check("midbusy_reset_nv_dout", NV_DOUT, 16'h0000);
        SCS = 1'b0;
        RESET_N = 1'b1;
        repeat (BUSY + 100) @(negedge CLK);
        nv_read("midbusy_nv20", 6'd20);
        send_cmd(2'b01, 6'd20);
        send_data(16'h2222, 16);
        cs_low();
        no_busy("ewen_cleared_no_busy");
        nv_read("ewen_cleared_nv20", 6'd20);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
